// File: rtl/ex_pkg.sv
// ============================================================================
//  Module      : ex_pkg
//  Description : Shared definitions for the execute stage: op-class selects,
//                op codes, multiplier FSM states and the default data width.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ex_pkg;

    // Default operand/result width
    localparam int EX_DATA_W = 32;

    // Op-class selects
    localparam logic [2:0] ALUSEL_LOGIC = 3'b001;
    localparam logic [2:0] ALUSEL_SHIFT = 3'b010;
    localparam logic [2:0] ALUSEL_MOVE  = 3'b011;
    localparam logic [2:0] ALUSEL_ARITH = 3'b100;
    localparam logic [2:0] ALUSEL_MUL   = 3'b101;

    // Logic op codes
    localparam logic [7:0] ALUOP_AND   = 8'b0010_0100;
    localparam logic [7:0] ALUOP_OR    = 8'b0010_0101;
    localparam logic [7:0] ALUOP_XOR   = 8'b0010_0110;
    localparam logic [7:0] ALUOP_NOR   = 8'b0010_0111;
    // Shift op codes
    localparam logic [7:0] ALUOP_SLL   = 8'b0111_1100;
    localparam logic [7:0] ALUOP_SRL   = 8'b0000_0010;
    localparam logic [7:0] ALUOP_SRA   = 8'b0000_0011;
    // Arithmetic op codes
    localparam logic [7:0] ALUOP_ADD   = 8'b0010_0000;
    localparam logic [7:0] ALUOP_ADDU  = 8'b0010_0001;
    localparam logic [7:0] ALUOP_SUB   = 8'b0010_0010;
    localparam logic [7:0] ALUOP_SUBU  = 8'b0010_0011;
    localparam logic [7:0] ALUOP_SLT   = 8'b0010_1010;
    localparam logic [7:0] ALUOP_SLTU  = 8'b0010_1011;
    // HI/LO move op codes
    localparam logic [7:0] ALUOP_MFHI  = 8'b0001_0000;
    localparam logic [7:0] ALUOP_MTHI  = 8'b0001_0001;
    localparam logic [7:0] ALUOP_MFLO  = 8'b0001_0010;
    localparam logic [7:0] ALUOP_MTLO  = 8'b0001_0011;
    // Multiply op codes
    localparam logic [7:0] ALUOP_MULT  = 8'b0001_1000;
    localparam logic [7:0] ALUOP_MULTU = 8'b0001_1001;

    // Iterative multiplier states
    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

`default_nettype wire

// File: rtl/ex_unit_if.sv
// ============================================================================
//  Module      : ex_unit_if
//  Description : Handshake and write-back bundle of the execute stage.
//                slave  = execute stage view, master = ID/EX + EX/MEM view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic              i_valid;
    logic              o_ready;
    logic              i_flush;
    logic [2:0]        i_alusel;
    logic [7:0]        i_aluop;
    logic [DATA_W-1:0] i_reg1_data;
    logic [DATA_W-1:0] i_reg2_data;
    logic              i_wreg;
    logic [REG_AW-1:0] i_wreg_addr;
    logic              o_valid;
    logic              i_ready;
    logic              o_wreg;
    logic [REG_AW-1:0] o_wreg_addr;
    logic [DATA_W-1:0] o_wreg_data;
    logic              o_ovf;
    logic              o_busy;

    modport slave (
        input  i_valid, i_flush, i_alusel, i_aluop, i_reg1_data, i_reg2_data,
               i_wreg, i_wreg_addr, i_ready,
        output o_ready, o_valid, o_wreg, o_wreg_addr, o_wreg_data, o_ovf, o_busy
    );

    modport master (
        output i_valid, i_flush, i_alusel, i_aluop, i_reg1_data, i_reg2_data,
               i_wreg, i_wreg_addr, i_ready,
        input  o_ready, o_valid, o_wreg, o_wreg_addr, o_wreg_data, o_ovf, o_busy
    );

endinterface

`default_nettype wire

// File: rtl/ex_mul_iter.sv
// ============================================================================
//  Module      : ex_mul_iter
//  Description : Iterative shift-add multiplier, one partial product per
//                cycle. Operates on magnitudes and restores the sign in DONE.
//                Present only when EX_MUL_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef EX_MUL_EN
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W
) (
    input  wire logic                clk,
    input  wire logic                rst_n,
    input  wire logic                start_i,
    input  wire logic                abort_i,
    input  wire logic                ack_i,
    input  wire logic                signed_i,
    input  wire logic [DATA_W-1:0]   a_i,
    input  wire logic [DATA_W-1:0]   b_i,
    output logic                     idle_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2*DATA_W-1:0]      product_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    mul_state_e          state_q;
    logic [2*DATA_W-1:0] mcand_q;
    logic [2*DATA_W-1:0] acc_q;
    logic [DATA_W-1:0]   mplier_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                neg_q;

    logic [DATA_W-1:0]   abs_a_w;
    logic [DATA_W-1:0]   abs_b_w;

    // Magnitudes; the most negative value maps to its unsigned magnitude
    assign abs_a_w = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
    assign abs_b_w = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;

    // Multiplier FSM: latch operands, iterate DATA_W times, hold result until acknowledged
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= MUL_IDLE;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
        end else if (abort_i) begin
            state_q  <= MUL_IDLE;
        end else begin
            case (state_q)
                MUL_IDLE: begin
                    if (start_i) begin
                        mcand_q  <= {{DATA_W{1'b0}}, abs_a_w};
                        mplier_q <= abs_b_w;
                        acc_q    <= '0;
                        neg_q    <= signed_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                        cnt_q    <= CNT_W'(DATA_W);
                        state_q  <= MUL_BUSY;
                    end
                end
                MUL_BUSY: begin
                    if (cnt_q == '0) begin
                        state_q <= MUL_DONE;
                    end else begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_q + mcand_q;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        cnt_q    <= cnt_q - 1'b1;
                    end
                end
                MUL_DONE: begin
                    if (ack_i) begin
                        state_q <= MUL_IDLE;
                    end
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign idle_o    = (state_q == MUL_IDLE);
    assign busy_o    = (state_q == MUL_BUSY);
    assign done_o    = (state_q == MUL_DONE);
    assign product_o = neg_q ? -acc_q : acc_q;

endmodule
`endif

`default_nettype wire

// File: rtl/ex_unit.sv
// ============================================================================
//  Module      : ex_unit
//  Description : Registered execute stage: logic, shift, add/sub/compare,
//                HI/LO moves and an optional iterative multiplier.
//                Build option: EX_MUL_EN enables the multiplier FSM and
//                HI/LO product path; without it MULT/MULTU are unknown ops.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_unit
    import ex_pkg::*;
#(
    parameter int DATA_W = EX_DATA_W,
    parameter int REG_AW = 5
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    ex_unit_if.slave   bus
);

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] hi_q;
    logic [DATA_W-1:0] lo_q;
    logic              o_valid_q;
    logic              o_wreg_q;
    logic [REG_AW-1:0] o_wreg_addr_q;
    logic [DATA_W-1:0] o_wreg_data_q;
    logic              o_ovf_q;

    logic [DATA_W-1:0] a_w;
    logic [DATA_W-1:0] b_w;
    logic [SHAMT_W-1:0] sh_w;
    logic [DATA_W-1:0] sum_w;
    logic [DATA_W-1:0] diff_w;
    logic [DATA_W-1:0] res_d;
    logic              wreg_d;
    logic              ovf_d;
    logic              is_mul_w;
    logic              adv_w;
    logic              accept_w;
    logic              mul_idle_w;
    logic              mul_busy_w;
    logic              mul_done_w;
    logic              is_mthi_w;
    logic              is_mtlo_w;

    assign a_w    = bus.i_reg1_data;
    assign b_w    = bus.i_reg2_data;
    assign sh_w   = a_w[SHAMT_W-1:0];
    assign sum_w  = a_w + b_w;
    assign diff_w = a_w - b_w;

    assign adv_w       = !o_valid_q || bus.i_ready;
    assign bus.o_ready = adv_w && mul_idle_w;
    assign accept_w    = bus.i_valid && bus.o_ready && !bus.i_flush;

    assign is_mthi_w = (bus.i_alusel == ALUSEL_MOVE) && (bus.i_aluop == ALUOP_MTHI);
    assign is_mtlo_w = (bus.i_alusel == ALUSEL_MOVE) && (bus.i_aluop == ALUOP_MTLO);

    // Decode and single-cycle ALU; unknown or mismatched ops give 0 with wreg passed through
    always_comb begin
        res_d    = '0;
        wreg_d   = bus.i_wreg;
        ovf_d    = 1'b0;
        is_mul_w = 1'b0;
        case (bus.i_alusel)
            ALUSEL_LOGIC: begin
                case (bus.i_aluop)
                    ALUOP_AND: res_d = a_w & b_w;
                    ALUOP_OR:  res_d = a_w | b_w;
                    ALUOP_XOR: res_d = a_w ^ b_w;
                    ALUOP_NOR: res_d = ~(a_w | b_w);
                    default:   res_d = '0;
                endcase
            end
            ALUSEL_SHIFT: begin
                case (bus.i_aluop)
                    ALUOP_SLL: res_d = b_w << sh_w;
                    ALUOP_SRL: res_d = b_w >> sh_w;
                    ALUOP_SRA: res_d = $signed(b_w) >>> sh_w;
                    default:   res_d = '0;
                endcase
            end
            ALUSEL_MOVE: begin
                case (bus.i_aluop)
                    ALUOP_MFHI: res_d = hi_q;
                    ALUOP_MFLO: res_d = lo_q;
                    ALUOP_MTHI,
                    ALUOP_MTLO: wreg_d = 1'b0;
                    default:    res_d = '0;
                endcase
            end
            ALUSEL_ARITH: begin
                case (bus.i_aluop)
                    ALUOP_ADD: begin
                        res_d = sum_w;
                        ovf_d = (a_w[DATA_W-1] == b_w[DATA_W-1]) &&
                                (sum_w[DATA_W-1] != a_w[DATA_W-1]);
                    end
                    ALUOP_ADDU: res_d = sum_w;
                    ALUOP_SUB: begin
                        res_d = diff_w;
                        ovf_d = (a_w[DATA_W-1] != b_w[DATA_W-1]) &&
                                (diff_w[DATA_W-1] != a_w[DATA_W-1]);
                    end
                    ALUOP_SUBU: res_d = diff_w;
                    ALUOP_SLT:  res_d = {{(DATA_W-1){1'b0}}, ($signed(a_w) < $signed(b_w))};
                    ALUOP_SLTU: res_d = {{(DATA_W-1){1'b0}}, (a_w < b_w)};
                    default:    res_d = '0;
                endcase
                if (ovf_d) begin
                    wreg_d = 1'b0;
                end
            end
            ALUSEL_MUL: begin
`ifdef EX_MUL_EN
                is_mul_w = (bus.i_aluop == ALUOP_MULT) || (bus.i_aluop == ALUOP_MULTU);
`endif
                res_d = '0;
            end
            default: res_d = '0;
        endcase
    end

`ifdef EX_MUL_EN
    logic [2*DATA_W-1:0] mul_prod_w;

    ex_mul_iter #(
        .DATA_W (DATA_W)
    ) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept_w && is_mul_w),
        .abort_i   (bus.i_flush),
        .ack_i     (adv_w && !bus.i_flush),
        .signed_i  (bus.i_aluop == ALUOP_MULT),
        .a_i       (a_w),
        .b_i       (b_w),
        .idle_o    (mul_idle_w),
        .busy_o    (mul_busy_w),
        .done_o    (mul_done_w),
        .product_o (mul_prod_w)
    );
`else
    assign mul_idle_w = 1'b1;
    assign mul_busy_w = 1'b0;
    assign mul_done_w = 1'b0;
`endif

    // HI/LO: MT* writes at acceptance, a finished multiply writes both halves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (!bus.i_flush) begin
            if (accept_w && is_mthi_w) begin
                hi_q <= a_w;
            end
            if (accept_w && is_mtlo_w) begin
                lo_q <= a_w;
            end
`ifdef EX_MUL_EN
            if (mul_done_w && adv_w) begin
                hi_q <= mul_prod_w[2*DATA_W-1:DATA_W];
                lo_q <= mul_prod_w[DATA_W-1:0];
            end
`endif
        end
    end

    // Output register: flush kills it, otherwise load on advance and hold on back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid_q     <= 1'b0;
            o_wreg_q      <= 1'b0;
            o_wreg_addr_q <= '0;
            o_wreg_data_q <= '0;
            o_ovf_q       <= 1'b0;
        end else if (bus.i_flush) begin
            o_valid_q <= 1'b0;
            o_wreg_q  <= 1'b0;
            o_ovf_q   <= 1'b0;
        end else if (adv_w) begin
            if (accept_w && !is_mul_w) begin
                o_valid_q     <= 1'b1;
                o_wreg_q      <= wreg_d;
                o_wreg_addr_q <= bus.i_wreg_addr;
                o_wreg_data_q <= res_d;
                o_ovf_q       <= ovf_d;
`ifdef EX_MUL_EN
            end else if (mul_done_w) begin
                o_valid_q     <= 1'b1;
                o_wreg_q      <= 1'b0;
                o_wreg_addr_q <= '0;
                o_wreg_data_q <= mul_prod_w[DATA_W-1:0];
                o_ovf_q       <= 1'b0;
`endif
            end else begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_valid     = o_valid_q;
    assign bus.o_wreg      = o_wreg_q;
    assign bus.o_wreg_addr = o_wreg_addr_q;
    assign bus.o_wreg_data = o_wreg_data_q;
    assign bus.o_ovf       = o_ovf_q;
    assign bus.o_busy      = mul_busy_w;

endmodule

`default_nettype wire

// File: tb/tb_ex_unit.sv
// ============================================================================
//  Module      : tb_ex_unit
//  Description : Self-checking bench for ex_unit. Directed ops push their
//                expected write-back into a queue; a monitor pops and compares
//                every output the DUT hands to EX/MEM.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_unit;
    import ex_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_unit_if #(.DATA_W(32), .REG_AW(5)) bus ();

    ex_unit #(.DATA_W(32), .REG_AW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    exp_t mon_g;
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
        end
    endtask

    // Scoreboard monitor: compare every output consumed by EX/MEM
    always @(negedge clk) begin
        if (rst_n && !bus.i_flush && bus.o_valid && bus.i_ready) begin
            n_chk++;
            mon_g = {bus.o_wreg, bus.o_wreg_addr, bus.o_wreg_data, bus.o_ovf};
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_output: got wreg=%0b addr=%0d data=0x%08h ovf=%0b, expected no output",
                         mon_g.w, mon_g.a, mon_g.d, mon_g.ovf);
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_g !== mon_e) begin
                    n_fail++;
                    $display("FAIL wb_output: got wreg=%0b addr=%0d data=0x%08h ovf=%0b, expected wreg=%0b addr=%0d data=0x%08h ovf=%0b",
                             mon_g.w, mon_g.a, mon_g.d, mon_g.ovf, mon_e.w, mon_e.a, mon_e.d, mon_e.ovf);
                end
            end
        end
    end

    // Present one op, wait (bounded) for acceptance, record its expected write-back
    task automatic send(input logic [2:0] sel, input logic [7:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic w, input logic [4:0] addr, input logic push,
                        input logic ew, input logic [31:0] ed, input logic eovf);
        int k;
        bus.i_valid     = 1'b1;
        bus.i_alusel    = sel;
        bus.i_aluop     = op;
        bus.i_reg1_data = a;
        bus.i_reg2_data = b;
        bus.i_wreg      = w;
        bus.i_wreg_addr = addr;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.o_ready && k < 200);
        if (!bus.o_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: got o_ready=0 after %0d cycles, expected 1", k);
        end else if (push) begin
            exp_q.push_back(exp_t'({ew, addr, ed, eovf}));
        end
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        logic busy1;
        bus.i_valid = 1'b0; bus.i_flush = 1'b0; bus.i_ready = 1'b1;
        bus.i_alusel = '0; bus.i_aluop = '0; bus.i_reg1_data = '0;
        bus.i_reg2_data = '0; bus.i_wreg = 1'b0; bus.i_wreg_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
        check("rst_o_wreg",  {31'd0, bus.o_wreg}, 32'd0);
        check("rst_addr",    {27'd0, bus.o_wreg_addr}, 32'd0);
        check("rst_data",    bus.o_wreg_data, 32'd0);
        check("rst_ovf",     {31'd0, bus.o_ovf}, 32'd0);
        check("rst_busy",    {31'd0, bus.o_busy}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Logic, latency 1
        send(ALUSEL_LOGIC, ALUOP_OR, 32'h0000F0F0, 32'h00000F0F, 1, 5'd3, 1, 1, 32'h0000FFFF, 0);
        check("or_latency_valid", {31'd0, bus.o_valid}, 32'd1);
        send(ALUSEL_LOGIC, ALUOP_AND, 32'hFF00FF00, 32'h0FF00FF0, 1, 5'd1, 1, 1, 32'h0F000F00, 0);
        send(ALUSEL_LOGIC, ALUOP_XOR, 32'hAAAA5555, 32'hFFFF0000, 1, 5'd2, 1, 1, 32'h55555555, 0);
        send(ALUSEL_LOGIC, ALUOP_NOR, 32'h0F0F0000, 32'h0000F0F0, 1, 5'd4, 1, 1, 32'hF0F00F0F, 0);

        // Arithmetic, overflow and compares
        send(ALUSEL_ARITH, ALUOP_ADD,  32'h7FFFFFFF, 32'h1, 1, 5'd4, 1, 0, 32'h80000000, 1);
        send(ALUSEL_ARITH, ALUOP_ADDU, 32'h7FFFFFFF, 32'h1, 1, 5'd5, 1, 1, 32'h80000000, 0);
        send(ALUSEL_ARITH, ALUOP_SUB,  32'h80000000, 32'h1, 1, 5'd6, 1, 0, 32'h7FFFFFFF, 1);
        send(ALUSEL_ARITH, ALUOP_SUBU, 32'h0, 32'h1, 1, 5'd7, 1, 1, 32'hFFFFFFFF, 0);
        send(ALUSEL_ARITH, ALUOP_ADD,  32'd100, 32'hFFFFFFFE, 1, 5'd8, 1, 1, 32'd98, 0);
        send(ALUSEL_ARITH, ALUOP_SLT,  32'hFFFFFFFF, 32'h1, 1, 5'd9, 1, 1, 32'h1, 0);
        send(ALUSEL_ARITH, ALUOP_SLTU, 32'hFFFFFFFF, 32'h1, 1, 5'd10, 1, 1, 32'h0, 0);

        // Shifts: amount mod 32, sign fill, zero amount
        send(ALUSEL_SHIFT, ALUOP_SRA, 32'h24, 32'h80000000, 1, 5'd11, 1, 1, 32'hF8000000, 0);
        send(ALUSEL_SHIFT, ALUOP_SLL, 32'd31, 32'h1, 1, 5'd12, 1, 1, 32'h80000000, 0);
        send(ALUSEL_SHIFT, ALUOP_SRL, 32'd4, 32'h800000F0, 1, 5'd13, 1, 1, 32'h0800000F, 0);
        send(ALUSEL_SHIFT, ALUOP_SRL, 32'h20, 32'h80000001, 1, 5'd14, 1, 1, 32'h80000001, 0);

        // Op/sel mismatch
        send(ALUSEL_LOGIC, ALUOP_ADD, 32'h1234, 32'h1, 1, 5'd15, 1, 1, 32'h0, 0);

        // HI/LO moves, read right after write
        send(ALUSEL_MOVE, ALUOP_MTHI, 32'h12345678, 32'h0, 1, 5'd16, 1, 0, 32'h0, 0);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd17, 1, 1, 32'h12345678, 0);
        send(ALUSEL_MOVE, ALUOP_MTLO, 32'hCAFEF00D, 32'h0, 1, 5'd18, 1, 0, 32'h0, 0);
        send(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0, 1, 5'd19, 1, 1, 32'hCAFEF00D, 0);

        // Back-pressure: hold 3 cycles, then release and accept the waiting op
        idle(2);
        bus.i_ready = 1'b0;
        send(ALUSEL_LOGIC, ALUOP_OR, 32'h11, 32'h22, 1, 5'd20, 1, 1, 32'h33, 0);
        bus.i_valid = 1'b1; bus.i_alusel = ALUSEL_LOGIC; bus.i_aluop = ALUOP_XOR;
        bus.i_reg1_data = 32'hFF00; bus.i_reg2_data = 32'h0FF0; bus.i_wreg = 1'b1; bus.i_wreg_addr = 5'd21;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, bus.o_valid}, 32'd1);
            check("hold_data",  bus.o_wreg_data, 32'h33);
            check("hold_ready", {31'd0, bus.o_ready}, 32'd0);
        end
        @(posedge clk); #1;
        bus.i_ready = 1'b1;
        exp_q.push_back(exp_t'({1'b1, 5'd21, 32'h0000F0F0, 1'b0}));
        @(negedge clk);
        check("release_ready", {31'd0, bus.o_ready}, 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        idle(2);

        // Flush kills a held result and wins over a simultaneous accept
        bus.i_ready = 1'b0;
        send(ALUSEL_LOGIC, ALUOP_AND, 32'hFFFF, 32'hFF, 1, 5'd22, 0, 0, 32'h0, 0);
        bus.i_valid = 1'b1; bus.i_alusel = ALUSEL_LOGIC; bus.i_aluop = ALUOP_OR;
        bus.i_reg1_data = 32'h1; bus.i_reg2_data = 32'h2; bus.i_wreg = 1'b1; bus.i_wreg_addr = 5'd23;
        bus.i_flush = 1'b1; bus.i_ready = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0; bus.i_valid = 1'b0;
        check("flush_kill_valid", {31'd0, bus.o_valid}, 32'd0);
        idle(2);
        check("flush_drop_valid", {31'd0, bus.o_valid}, 32'd0);

`ifdef EX_MUL_EN
        // MULT -3 x 5: stall length, then HI/LO readback
        send(ALUSEL_MUL, ALUOP_MULT, 32'hFFFFFFFD, 32'd5, 1, 5'd0, 1, 0, 32'hFFFFFFF1, 0);
        stall = 0;
        @(negedge clk);
        busy1 = bus.o_busy;
        while (!bus.o_ready && stall < 100) begin
            stall++;
            @(negedge clk);
        end
        check("mult_busy", {31'd0, busy1}, 32'd1);
        check("mult_stall_cycles", stall, 32'd34);
        send(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0, 1, 5'd24, 1, 1, 32'hFFFFFFF1, 0);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd25, 1, 1, 32'hFFFFFFFF, 0);
        send(ALUSEL_MUL, ALUOP_MULT, 32'h80000000, 32'h80000000, 1, 5'd0, 1, 0, 32'h0, 0);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd26, 1, 1, 32'h40000000, 0);
        send(ALUSEL_MUL, ALUOP_MULTU, 32'hFFFFFFFF, 32'd2, 1, 5'd0, 1, 0, 32'hFFFFFFFE, 0);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd27, 1, 1, 32'h00000001, 0);

        // Flush while BUSY: back to IDLE, HI/LO untouched
        send(ALUSEL_MUL, ALUOP_MULT, 32'd7, 32'd9, 1, 5'd0, 0, 0, 32'h0, 0);
        repeat (5) @(negedge clk);
        check("flush_pre_busy", {31'd0, bus.o_busy}, 32'd1);
        @(posedge clk); #1;
        bus.i_flush = 1'b1;
        @(posedge clk); #1;
        bus.i_flush = 1'b0;
        check("flush_busy_cleared", {31'd0, bus.o_busy}, 32'd0);
        check("flush_ready", {31'd0, bus.o_ready}, 32'd1);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd28, 1, 1, 32'h00000001, 0);
        send(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0, 1, 5'd29, 1, 1, 32'hFFFFFFFE, 0);

        // Reset in the middle of a multiply
        send(ALUSEL_MUL, ALUOP_MULT, 32'd7, 32'd9, 1, 5'd0, 0, 0, 32'h0, 0);
        repeat (3) @(negedge clk);
        check("rst_pre_busy", {31'd0, bus.o_busy}, 32'd1);
`else
        // Without the multiplier MULT is an unknown single-cycle op
        send(ALUSEL_MUL, ALUOP_MULT, 32'hFFFFFFFD, 32'd5, 1, 5'd7, 1, 1, 32'h0, 0);
        check("nomul_busy", {31'd0, bus.o_busy}, 32'd0);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd24, 1, 1, 32'h12345678, 0);
        send(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0, 1, 5'd25, 1, 1, 32'hCAFEF00D, 0);
        send(ALUSEL_MOVE, ALUOP_MTHI, 32'h5555AAAA, 32'h0, 1, 5'd26, 1, 0, 32'h0, 0);
        @(negedge clk);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy",  {31'd0, bus.o_busy}, 32'd0);
        check("async_rst_valid", {31'd0, bus.o_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send(ALUSEL_MOVE, ALUOP_MFHI, 32'h0, 32'h0, 1, 5'd30, 1, 1, 32'h0, 0);
        send(ALUSEL_MOVE, ALUOP_MFLO, 32'h0, 32'h0, 1, 5'd31, 1, 1, 32'h0, 0);

        // Drain the scoreboard
        stall = 0;
        while (exp_q.size() != 0 && stall < 50) begin
            @(posedge clk);
            stall++;
        end
        #1;
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ex_unit.md
Name: ex_unit

Overview:
- Registered, parametrised execute stage for the in-order core. Sits between ID/EX and EX/MEM.
- Covers logic, shift, add/sub/compare, HI/LO moves, and an iterative shift-add multiplier that stalls upstream while busy.
- Uses a valid/ready handshake on both sides and drives the EX/MEM write-back fields from an output register.

Parameters:
- DATA_W, 32: operand/result width; must be a power of 2, ≥ 8.
- REG_AW, 5: register address width.
- SHAMT_W, $clog2(DATA_W): shift-amount width, derived; do not override.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  ID/EX holds an op.
- o_ready  out  1  unit accepts an op this cycle.
- i_flush  in  1  kill the in-flight op and the output register.
- i_alusel  in  3  op class: 001 logic, 010 shift, 011 move, 100 arith, 101 mul.
- i_aluop  in  8  op code.
- i_reg1_data  in  DATA_W  operand A; for shifts, its low SHAMT_W bits are the shift amount.
- i_reg2_data  in  DATA_W  operand B; for shifts, the value being shifted.
- i_wreg  in  1  op writes the GPR file.
- i_wreg_addr  in  REG_AW  destination register.
- o_valid  out  1  output register holds a result.
- i_ready  in  1  EX/MEM consumes the result.
- o_wreg  out  1  write enable.
- o_wreg_addr  out  REG_AW  destination register.
- o_wreg_data  out  DATA_W  result.
- o_ovf  out  1  signed add/sub overflow.
- o_busy  out  1  multiplier iterating.

Behaviour:
- Op codes:
  - Logic: AND 00100100, OR 00100101, XOR 00100110, NOR 00100111.
  - Shift: SLL 01111100, SRL 00000010, SRA 00000011.
  - Arith: ADD 00100000, ADDU 00100001, SUB 00100010, SUBU 00100011, SLT 00101010, SLTU 00101011.
  - Move: MFHI 00010000, MTHI 00010001, MFLO 00010010, MTLO 00010011.
  - Mul: MULT 00011000, MULTU 00011001.
  - Any op/sel mismatch or unknown code gives result 0 with o_wreg passed through.
- Reset (async, rst_n=0):
  - o_valid, o_wreg, o_ovf, o_busy = 0; o_wreg_addr = 0; o_wreg_data = 0.
  - HI = LO = 0; FSM = IDLE.
  - Reset mid-multiply aborts it; HI/LO read 0.
- Advance condition: adv = !o_valid || i_ready. o_ready = adv && state==IDLE.
- Single-cycle ops:
  - Accepted when i_valid && o_ready; result appears in the output register the next cycle (latency 1).
  - Back-to-back ops run at full throughput when i_ready stays high.
  - If o_valid && !i_ready, all outputs hold.
- Shifts:
  - Shift amount taken mod DATA_W.
  - SRA sign-fills.
  - Shift amount 0 returns B unchanged.
- Arithmetic:
  - ADD/SUB compute a signed overflow, e.g. 7FFFFFFF+1.
  - On overflow: o_ovf=1, o_wreg forced 0, o_wreg_data = wrapped sum.
  - ADDU/SUBU never flag overflow; both wrap.
  - SLT compares signed, SLTU compares unsigned; result is 0 or 1 zero-extended.
- Moves:
  - MTHI/MTLO write HI/LO from A at acceptance and emit o_wreg=0.
  - MFHI/MFLO read HI/LO, including a value written by the immediately preceding MT*/MULT.
- Multiplier FSM, states IDLE → BUSY → DONE → IDLE:
  - IDLE→BUSY: on accepting MULT/MULTU. Latch operand magnitudes (abs value for MULT) and the result sign; count = DATA_W.
  - BUSY: one shift-add iteration per cycle; count decrements; o_busy=1; o_ready=0. Exit when count reaches 0.
  - DONE:
    - Apply the sign (two's-complement negate of the 2·DATA_W product when signs differ).
    - Write {HI,LO}.
    - Push an output with o_wreg=0, waiting in DONE until adv is true.
  - Latency from acceptance to output-valid: DATA_W+2 cycles.
  - MULT of 0x80000000 × 0x80000000 gives HI=0x40000000, LO=0.
- Flush:
  - i_flush clears o_valid and returns the FSM to IDLE; HI/LO are left unchanged for an aborted multiply.
  - Flush takes priority over a simultaneous accept; the input that cycle is dropped.

Optional Feature:
- EX_MUL_EN
- Defined: multiplier FSM, HI/LO product path and o_busy are present as described.
- Undefined:
  - No FSM. o_busy tied 0.
  - MULT/MULTU are treated as unknown ops: single-cycle, result 0, HI/LO unchanged.
  - MT*/MF* still operate.

Decomposition:
- Package ex_pkg holds:
  - ALUSEL_* and ALUOP_* localparams.
  - The mul FSM state enum (IDLE, BUSY, DONE).
  - The DATA_W default.
- One sub-module, ex_mul_iter, holds the shift-add core: start, operands, signed flag, busy, done, 2·DATA_W product.
- ex_unit keeps the decode, the single-cycle ALU, HI/LO and the output register.

Test Plan:
- OR A=0x0000F0F0, B=0x00000F0F, wreg=1, addr=3 → next cycle o_valid=1, data=0x0000FFFF, addr=3, o_wreg=1.
- ADD 0x7FFFFFFF+1 → o_ovf=1, o_wreg=0. ADDU with the same operands → data=0x80000000, o_ovf=0.
- SRA B=0x80000000, A=0x24 → amount 4 → data=0xF8000000. SLT -1<1 → 1. SLTU 0xFFFFFFFF<1 → 0.
- MULT -3×5 (EX_MUL_EN):
  - o_ready=0 for 34 cycles.
  - Then MFLO → 0xFFFFFFF1 and MFHI → 0xFFFFFFFF.
- Hold i_ready=0 for 3 cycles with o_valid=1 → outputs stable, o_ready=0. Release → next op accepted that same cycle.
- Assert rst_n=0 mid-MULT → o_busy=0, o_valid=0, HI=LO=0 immediately. i_flush during BUSY → IDLE next cycle, HI/LO unchanged.
